// File: rtl/timer_ctrl_multi.sv
// Multi-channel timer control: TCSR flags, interrupts, counter clear, TMO pins,
// ADC trigger and registered clock-select for NUM_CH 8-bit timer channels.
module timer_ctrl_multi #(
  parameter int unsigned NUM_CH               = 2,
  parameter int unsigned BIT_WIDTH            = 8,
  parameter int unsigned CLK_SELECT_BIT_WIDTH = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_CH*BIT_WIDTH-1:0]            tcr,
  input  logic [NUM_CH*BIT_WIDTH-1:0]            tccr,
  input  logic [NUM_CH-1:0]                      tcsr_we,
  input  logic [BIT_WIDTH-1:0]                   tcsr_wdata,
  output logic [NUM_CH*BIT_WIDTH-1:0]            tcsr_rdata,
  input  logic [NUM_CH-1:0]                      cmp_a,
  input  logic [NUM_CH-1:0]                      cmp_b,
  input  logic [NUM_CH-1:0]                      ovf,
  input  logic [NUM_CH-1:0]                      tmri,
  output logic [NUM_CH-1:0]                      counter_clear,
  output logic [NUM_CH-1:0]                      cmia,
  output logic [NUM_CH-1:0]                      cmib,
  output logic [NUM_CH-1:0]                      ovi,
  output logic [NUM_CH-1:0]                      tmo,
  output logic                                   adc_request,
  output logic [NUM_CH*CLK_SELECT_BIT_WIDTH-1:0] clock_select
);

  localparam int unsigned SYNC_W = 3;

  // ADTE exists only on channel 0, so it lives outside the per-channel block
  logic adte_q;
  logic adc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      adte_q <= 1'b0;
      adc_q  <= 1'b0;
    end else begin
      if (tcsr_we[0]) adte_q <= tcsr_wdata[4];
      adc_q <= cmp_a[0] & adte_q;
    end
  end

  assign adc_request = adc_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [BIT_WIDTH-1:0]            tcr_i;
    logic [BIT_WIDTH-1:0]            tccr_i;
    logic                            cmfa_q, cmfb_q, ovf_q;
    logic [1:0]                      osa_q, osb_q;
    logic                            tmo_q, tmo_nxt;
    logic                            clr_q, clr_nxt;
    logic [SYNC_W-1:0]               sync_q;
    logic [CLK_SELECT_BIT_WIDTH-1:0] cks_q;
    logic [1:0]                      os_sel;
    logic                            os_hit;
    logic                            s2, s3;
    logic                            adte_bit;
    logic                            unused_tccr_bits;

    assign tcr_i            = tcr[i*BIT_WIDTH +: BIT_WIDTH];
    assign tccr_i           = tccr[i*BIT_WIDTH +: BIT_WIDTH];
    assign unused_tccr_bits = ^{tccr_i[7:4], tccr_i[2:0]};
    assign s2               = sync_q[1];
    assign s3               = sync_q[2];
    assign adte_bit         = (i == 0) ? adte_q : 1'b0;

    // OSB takes precedence when both compares hit in the same cycle
    always_comb begin
      os_sel  = osa_q;
      os_hit  = cmp_a[i];
      tmo_nxt = tmo_q;
      if (cmp_b[i]) begin
        os_sel = osb_q;
        os_hit = 1'b1;
      end
      if (os_hit) begin
        case (os_sel)
          2'b01:   tmo_nxt = 1'b0;
          2'b10:   tmo_nxt = 1'b1;
          2'b11:   tmo_nxt = ~tmo_q;
          default: tmo_nxt = tmo_q;
        endcase
      end
    end

    // TMRIS selects level (s2) or rising-edge (s2 & ~s3) clearing
    always_comb begin
      clr_nxt = 1'b0;
      case (tcr_i[4:3])
        2'b01:   clr_nxt = cmp_a[i];
        2'b10:   clr_nxt = cmp_b[i];
        2'b11:   clr_nxt = tccr_i[3] ? s2 : (s2 & ~s3);
        default: clr_nxt = 1'b0;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cmfa_q <= 1'b0;
        cmfb_q <= 1'b0;
        ovf_q  <= 1'b0;
        osa_q  <= 2'b00;
        osb_q  <= 2'b00;
        tmo_q  <= 1'b0;
        clr_q  <= 1'b0;
        sync_q <= '0;
        cks_q  <= '0;
      end else begin
        // writing 0 clears a flag, but a same-cycle event keeps it set
        cmfa_q <= cmp_a[i] | (cmfa_q & ~(tcsr_we[i] & ~tcsr_wdata[6]));
        cmfb_q <= cmp_b[i] | (cmfb_q & ~(tcsr_we[i] & ~tcsr_wdata[7]));
        ovf_q  <= ovf[i]   | (ovf_q  & ~(tcsr_we[i] & ~tcsr_wdata[5]));
        if (tcsr_we[i]) begin
          osa_q <= tcsr_wdata[1:0];
          osb_q <= tcsr_wdata[3:2];
        end
        tmo_q  <= tmo_nxt;
        clr_q  <= clr_nxt;
        sync_q <= {sync_q[SYNC_W-2:0], tmri[i]};
        cks_q  <= tcr_i[CLK_SELECT_BIT_WIDTH-1:0];
      end
    end

    assign tcsr_rdata[i*BIT_WIDTH +: BIT_WIDTH] =
      {cmfb_q, cmfa_q, ovf_q, adte_bit, osb_q, osa_q};
    assign cmia[i]          = cmfa_q & tcr_i[6];
    assign cmib[i]          = cmfb_q & tcr_i[7];
    assign ovi[i]           = ovf_q  & tcr_i[5];
    assign tmo[i]           = tmo_q;
    assign counter_clear[i] = clr_q;
    assign clock_select[i*CLK_SELECT_BIT_WIDTH +: CLK_SELECT_BIT_WIDTH] = cks_q;
  end

endmodule

// File: tb/tb_timer_ctrl_multi.sv
// Directed bench for timer_ctrl_multi: table-driven flag/TMO vectors on ch 1
// plus hand sequences for reset, TMO priority, counter clear, ADC and clock select.
module tb_timer_ctrl_multi;
  localparam int unsigned NCH = 4;
  localparam int unsigned BW  = 8;
  localparam int unsigned CW  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH*BW-1:0] tcr, tccr, tcsr_rdata;
  logic [NCH-1:0]    tcsr_we, cmp_a, cmp_b, ovf, tmri;
  logic [BW-1:0]     tcsr_wdata;
  logic [NCH-1:0]    counter_clear, cmia, cmib, ovi, tmo;
  logic              adc_request;
  logic [NCH*CW-1:0] clock_select;

  int checks = 0;
  int errors = 0;

  timer_ctrl_multi #(.NUM_CH(NCH), .BIT_WIDTH(BW), .CLK_SELECT_BIT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .tcr(tcr), .tccr(tccr), .tcsr_we(tcsr_we),
    .tcsr_wdata(tcsr_wdata), .tcsr_rdata(tcsr_rdata), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .ovf(ovf), .tmri(tmri), .counter_clear(counter_clear), .cmia(cmia), .cmib(cmib),
    .ovi(ovi), .tmo(tmo), .adc_request(adc_request), .clock_select(clock_select)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       a, b, o, we;
    logic [7:0] wd;
    logic [7:0] exp_tcsr;
    logic       exp_cmia;
    logic       exp_tmo;
  } vec_t;

  vec_t vt[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    tcsr_we = '0; cmp_a = '0; cmp_b = '0; ovf = '0; tcsr_wdata = '0;
  endtask

  task automatic wr(input int ch, input logic [7:0] d);
    tcsr_we = NCH'(1) << ch;
    tcsr_wdata = d;
  endtask

  logic [7:0] b;
  logic [NCH*CW-1:0] exp_cs;

  initial begin
    // ch1 vectors: flag set/clear, set-wins-over-clear, ADTE ignored off ch 0, OS toggles
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h40, 1'b1, 1'b0};
    vt[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hBF, 8'h0F, 1'b0, 1'b0};
    vt[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hBF, 8'h4F, 1'b1, 1'b1};
    vt[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hCF, 1'b1, 1'b0};
    vt[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hEF, 1'b1, 1'b0};
    vt[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
    vt[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h0F, 1'b0, 1'b0};
    vt[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h4F, 1'b1, 1'b1};
    vt[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hCF, 1'b1, 1'b0};
    vt[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hCF, 1'b1, 1'b0};

    tcr = '0; tccr = '0; tmri = '0; idle();
    rst = 1'b1; cmp_a = '1;
    step(); step();
    check("rst_tcsr", 32'(tcsr_rdata), 32'h0);
    check("rst_tmo", 32'(tmo), 32'h0);
    check("rst_clr", 32'(counter_clear), 32'h0);
    check("rst_adc", 32'(adc_request), 32'h0);
    check("rst_cs", 32'(clock_select), 32'h0);
    check("rst_irq", 32'({cmia, cmib, ovi}), 32'h0);
    rst = 1'b0; cmp_a = '0;
    step();
    check("post_rst_tcsr", 32'(tcsr_rdata), 32'h0);

    tcr[1*BW +: BW] = 8'h40;
    for (int i = 0; i < 10; i++) begin
      cmp_a = NCH'(vt[i].a) << 1;
      cmp_b = NCH'(vt[i].b) << 1;
      ovf   = NCH'(vt[i].o) << 1;
      tcsr_we = NCH'(vt[i].we) << 1;
      tcsr_wdata = vt[i].wd;
      step();
      check($sformatf("vec%0d_tcsr", i), 32'(tcsr_rdata[1*BW +: BW]), 32'(vt[i].exp_tcsr));
      check($sformatf("vec%0d_cmia", i), 32'(cmia[1]), 32'(vt[i].exp_cmia));
      check($sformatf("vec%0d_tmo", i), 32'(tmo[1]), 32'(vt[i].exp_tmo));
      check($sformatf("vec%0d_clr", i), 32'(counter_clear[1]), 32'h0);
    end
    idle();

    // TMO on ch 0: OSA=10, OSB=01, then OSB=11 with simultaneous compares
    wr(0, 8'hE6); step(); idle();
    cmp_a = 4'b0001; step(); idle();
    check("tmo_osa_drive1", 32'(tmo[0]), 32'h1);
    check("adc_off_no_req", 32'(adc_request), 32'h0);
    check("cclr00_no_clr", 32'(counter_clear[0]), 32'h0);
    cmp_b = 4'b0001; step(); idle();
    check("tmo_osb_drive0", 32'(tmo[0]), 32'h0);
    wr(0, 8'hEE); step(); idle();
    cmp_a = 4'b0001; cmp_b = 4'b0001; step(); idle();
    check("tmo_both_osb_toggle", 32'(tmo[0]), 32'h1);

    // CCLR=10 on ch 2: one-cycle clear after cmp_b
    tcr[2*BW +: BW] = 8'h10;
    cmp_a = 4'b0100; step(); idle();
    check("cclr10_ignores_cmp_a", 32'(counter_clear[2]), 32'h0);
    cmp_b = 4'b0100; step(); idle();
    check("cclr10_pulse", 32'(counter_clear[2]), 32'h1);
    step();
    check("cclr10_pulse_end", 32'(counter_clear[2]), 32'h0);

    // CCLR=11, TMRIS=0: single pulse 3 edges after the tmri rise
    tcr[2*BW +: BW] = 8'h18;
    tccr[2*BW +: BW] = 8'h00;
    tmri[2] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      check($sformatf("tmris0_k%0d", k), 32'(counter_clear[2]), 32'(k == 3));
      if (k == 5) tmri[2] = 1'b0;
    end

    // TMRIS=1: level clear, high for 5 cycles starting 3 edges after rise
    tccr[2*BW +: BW] = 8'h08;
    tmri[2] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      check($sformatf("tmris1_k%0d", k), 32'(counter_clear[2]), 32'(k >= 3 && k <= 7));
      if (k == 5) tmri[2] = 1'b0;
    end

    // ADC trigger on ch 0
    wr(0, 8'hFE); step(); idle();
    b = tcsr_rdata[7:0];
    check("adte_ch0_readback", 32'(b[4]), 32'h1);
    cmp_a = 4'b0001; step(); idle();
    check("adc_pulse", 32'(adc_request), 32'h1);
    step();
    check("adc_pulse_end", 32'(adc_request), 32'h0);

    // all channels at once
    cmp_a = '1; cmp_b = '1; ovf = '1; step(); idle();
    for (int c = 0; c < NCH; c++) begin
      b = tcsr_rdata[c*BW +: BW];
      check($sformatf("all_flags_ch%0d", c), 32'(b[7:5]), 32'h7);
    end

    // clock_select follows CKS one cycle later
    exp_cs = {3'd5, 3'd3, 3'd6, 3'd1};
    tcr = {8'h05, 8'h1B, 8'h46, 8'h01};
    #2;
    check("cs_not_yet", 32'(clock_select), 32'h0);
    step();
    for (int c = 0; c < NCH; c++)
      check($sformatf("cs_ch%0d", c), 32'(clock_select[c*CW +: CW]), 32'(exp_cs[c*CW +: CW]));

    // mid-operation reset overrides events and writes
    rst = 1'b1; cmp_a = '1; cmp_b = '1; wr(0, 8'hFF);
    step(); idle(); rst = 1'b0;
    check("midrst_tcsr", 32'(tcsr_rdata), 32'h0);
    check("midrst_tmo", 32'(tmo), 32'h0);
    check("midrst_clr_adc", 32'({counter_clear, adc_request}), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/timer_ctrl_multi.md
# timer_ctrl_multi

Parametrised control unit for the 8-bit timer family, generalised to NUM_CH channels of BIT_WIDTH-bit control registers. It takes per-channel compare-match and overflow pulses from the counter datapaths and owns the TCSR status flags and their clearing, the interrupt requests and counter-clear generation. It also drives the timer output (TMO) pins, the ADC start request and each channel's clock-select code. It sits between the register bus block and the per-channel counters.

## Interface
- NUM_CH, 2, number of timer channels (1..8)
- BIT_WIDTH, 8, width of TCR/TCCR/TCSR per channel (fixed bit map below; must be 8)
- CLK_SELECT_BIT_WIDTH, 3, width of per-channel clock-select code
---
- clk  in  1  single clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- tcr  in  NUM_CH*BIT_WIDTH  TCR per channel, ch i at [i*8+:8]: [7] CMIEB, [6] CMIEA, [5] OVIE, [4:3] CCLR, [2:0] CKS
- tccr  in  NUM_CH*BIT_WIDTH  TCCR per channel: [3] TMRIS; other bits ignored
- tcsr_we  in  NUM_CH  per-channel TCSR write strobe
- tcsr_wdata  in  BIT_WIDTH  TCSR write data (shared)
- tcsr_rdata  out  NUM_CH*BIT_WIDTH  TCSR per channel: [7] CMFB, [6] CMFA, [5] OVF, [4] ADTE, [3:2] OSB, [1:0] OSA
- cmp_a, cmp_b, ovf  in  NUM_CH each  one-cycle event pulses from counters
- tmri  in  NUM_CH  external counter-reset inputs (asynchronous)
- counter_clear  out  NUM_CH  counter clear request
- cmia, cmib, ovi  out  NUM_CH each  interrupt requests
- tmo  out  NUM_CH  timer output pins
- adc_request  out  1  ADC start pulse
- clock_select  out  NUM_CH*CLK_SELECT_BIT_WIDTH  registered copy of CKS per channel

## Operation
- Flags: cmp_a sets CMFA, cmp_b sets CMFB, ovf sets OVF. A TCSR write with a flag bit = 0 clears that flag; bit = 1 leaves it unchanged. A set event in the same cycle as a clearing write wins (flag stays 1).
- A TCSR write loads bits [4:0] directly. ADTE is implemented only on ch 0; on other channels it reads 0 and writes are ignored.
- Interrupts: cmia = CMFA & CMIEA, cmib = CMFB & CMIEB, ovi = OVF & OVIE. These are combinational from the flag registers and tcr, so they follow flags and enable changes in the same cycle.
- TMI sync: tmri passes through a 2-FF synchroniser (s2), plus one history flop (s3).
- CCLR = 00: no clear.
- CCLR = 01: clear on cmp_a.
- CCLR = 10: clear on cmp_b.
- CCLR = 11: clear from the synchronised TMRI. With TMRIS = 1, counter_clear follows s2 (level-high). With TMRIS = 0, counter_clear is a one-cycle pulse when s2 & ~s3 (rising edge).
- TMO action select, OSA on cmp_a and OSB on cmp_b: 00 no change, 01 drive 0, 10 drive 1, 11 toggle.
- If cmp_a and cmp_b occur in the same cycle, the OSB action is applied and OSA is ignored.
- adc_request is a one-cycle pulse on ch 0 cmp_a when ADTE = 1.
- clock_select[i] is CKS of channel i, registered.

## Timing
- Reset values: all flags, ADTE, OSA, OSB = 0; tmo = 0; counter_clear = 0; adc_request = 0; clock_select = 0; synchroniser flops = 0. Hence cmia, cmib and ovi are 0.
- Flag and tmo latency: an event at edge N is visible after edge N+1.
- cmp-based counter_clear and adc_request are registered: they assert for exactly one cycle, in the cycle after the event.
- TMRI latency: a tmri rise before edge N is seen in s2 after edge N+1. counter_clear then asserts after edge N+2.
- Write latency: tcsr_rdata reflects a write in the cycle after tcsr_we.
- rst asserted mid-operation forces the reset values at the next edge, overriding simultaneous events and writes.
- clock_select updates one cycle after a tcr change.
- Channels are fully independent. Simultaneous events on all channels are all captured.

## Test plan
- Reset: assert rst for 2 cycles with cmp_a held high. Required: every output 0, and tcsr_rdata = 0 on the cycle after release.
- Flag set/clear: ch 1 cmp_a pulse, then write 0xBF with CMIEA = 1. Required: CMFA = 1 and cmia = 1 one cycle after the pulse; both 0 one cycle after the write. Repeating the write with a simultaneous cmp_a pulse leaves CMFA = 1.
- TMO: ch 0 with OSA = 10 and OSB = 01. A cmp_a pulse gives tmo = 1; a cmp_b pulse gives tmo = 0. Simultaneous cmp_a and cmp_b with OSA = 10, OSB = 11 starting from tmo = 0 gives tmo = 1 (toggle).
- Counter clear: CCLR = 10 with a cmp_b pulse gives a 1-cycle counter_clear. CCLR = 11, TMRIS = 0, with tmri held high for 5 cycles gives a single pulse 3 edges after the rise. With TMRIS = 1, counter_clear stays high for 5 cycles, delayed by 2.
- ADC: ch 0 ADTE = 1 with cmp_a gives one adc_request pulse. A ch 1 write of ADTE = 1 reads back 0.
- NUM_CH = 4: events on all channels in one cycle set all flags. Each channel's clock_select matches its CKS one cycle after the tcr change.
